cpu_poll_sched: RTL and testbench
=================================

// Module: cpu_poll_sched
// PURPOSE
//  Round-robin scheduler sharing one 64-bit result channel between CPU_NB DPI CPU-server lanes.
//  Each lane offers data with valid/ready; the block grants one lane per cycle and forwards its word
//  with the lane index. It counts TXN_NB transactions per lane and raises all_done, so top-level $finish works.
//  Sits between the per-CPU DPI polling generate blocks and the checker/consumer.
// PARAMETERS
//  CPU_NB   4    number of requesting CPU lanes (>=2)
//  TXN_NB   16   transactions expected per lane before lane is retired (>=1)
//  WDOG_CYC 64   max cycles a lane may wait with req_vld high and no grant (watchdog only)
// PORTS
//  clk        in   1            clock, all logic on posedge
//  rst        in   1            synchronous reset, active-high
//  start      in   1            pulse; IDLE->RUN, ignored in other states
//  req_vld    in   CPU_NB       lane i has a word
//  req_data   in   CPU_NB x 64  lane data, packed [CPU_NB-1:0][63:0]
//  req_rdy    out  CPU_NB       one-hot (or 0) grant; transfer when req_vld[i] & req_rdy[i]
//  out_vld    out  1            output register holds a word
//  out_data   out  64           forwarded word
//  out_cpu    out  $clog2(CPU_NB) source lane of out_data
//  out_rdy    in   1            consumer accepts when out_vld & out_rdy
//  busy       out  1            state is RUN or DRAIN
//  all_done   out  1            state is DONE (sticky until rst)
//  wdog_err   out  1            present only with CPU_SCHED_WDOG_EN
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, all counters 0, req_rdy=0, out_vld=0, out_data=0, out_cpu=0,
//   busy=0, all_done=0, wdog_err=0. rst mid-transfer discards output register and all counts.
//  FSM: IDLE -start-> RUN; RUN -all lanes retired-> DRAIN; DRAIN -out register empty-> DONE;
//   DONE terminal. If last retiring transfer and output-empty coincide, RUN->DRAIN still taken
//   (one DRAIN cycle min).
//  Eligible lane i: state==RUN, req_vld[i], cnt[i]<TXN_NB.
//  Slot free = !out_vld | out_rdy (same-cycle accept and refill allowed; full throughput 1/cycle).
//  req_rdy is combinational: one-hot on first eligible lane searching from rr_ptr upward mod CPU_NB,
//   only when slot free; otherwise 0. Retired lanes never see req_rdy.
//  On transfer from lane g: out_data<=req_data[g], out_cpu<=g, out_vld<=1 next cycle
//   (latency 1), cnt[g]++, rr_ptr<=(g+1) mod CPU_NB. No grant: rr_ptr holds.
//  out_vld & out_rdy with no new grant -> out_vld<=0 next cycle; out_data holds last value.
//  Counters width $clog2(TXN_NB+1); never exceed TXN_NB.
//  Outputs stable while out_vld & !out_rdy (no drop, no overwrite).
// CONFIGURATION
//  CPU_SCHED_WDOG_EN defined: per-lane wait counter, increments while eligible & not granted,
//   clears on grant or when ineligible; reaching WDOG_CYC sets wdog_err sticky until rst and issues
//   $error naming the lane. Not defined: no counters, no wdog_err port, behaviour otherwise identical.
// STRUCTURE
//  Package cpu_sched_pkg: data_t (logic [63:0]), state_e {IDLE,RUN,DRAIN,DONE}, DATA_W=64 constant.
//  Sub-module cpu_rr_arb (#CPU_NB): inputs eligible vector + ptr, outputs one-hot grant + index;
//   purely combinational, instantiated once. FSM, counters and output register stay in cpu_poll_sched.
// TESTING
//  1 rst, start, CPU_NB=4, all req_vld=1 out_rdy=1 -> grants 0,1,2,3,0.. one per cycle; DONE after 64 transfers+drain.
//  2 Only lane 2 valid, data 0xDEAD_BEEF_0000_0002 -> out_cpu=2, out_data matches 1 cycle after grant.
//  3 out_rdy=0 for 5 cycles with out_vld=1 -> req_rdy=0, out_data/out_cpu frozen; resume without loss.
//  4 Lane 1 reaches TXN_NB=16 early -> req_rdy[1] stays 0 though req_vld[1]=1; others continue.
//  5 rst asserted mid-RUN with out_vld=1 -> next cycle all outputs at reset values, cnt=0, start required.
//  6 WDOG_EN, WDOG_CYC=8, out_rdy=0 with lane 3 valid 8 cycles -> wdog_err=1, stays 1 until rst.

Source files
------------

// File: rtl/cpu_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_sched_pkg
//  Purpose  : Shared types and constants for the CPU-lane polling scheduler.
//             DATA_W  - width of one forwarded result word
//             data_t  - result word type
//             state_e - scheduler FSM states (IDLE, RUN, DRAIN, DONE)
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_sched_pkg;

    localparam int DATA_W = 64;

    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage : cpu_sched_pkg
`default_nettype wire

// File: rtl/cpu_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_rr_arb
//  Purpose  : Purely combinational round-robin picker. Starting at i_ptr and
//             moving upward modulo CPU_NB, selects the first set bit of
//             i_elig.
//  Ports    : i_elig [CPU_NB]  lanes allowed to transfer this cycle
//             i_ptr            lane with highest priority this cycle
//             o_gnt  [CPU_NB]  one-hot grant, all zero when nothing eligible
//             o_idx            index of the granted lane (0 when no grant)
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_rr_arb #(
    parameter int CPU_NB = 4
) (
    input  logic [CPU_NB-1:0]         i_elig,
    input  logic [$clog2(CPU_NB)-1:0] i_ptr,
    output logic [CPU_NB-1:0]         o_gnt,
    output logic [$clog2(CPU_NB)-1:0] o_idx
);

    localparam int PTR_W = $clog2(CPU_NB);

    always_comb begin
        logic w_found;
        int   w_pos;
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_pos   = 0;
        // Walk the lanes in priority order; the first eligible one wins.
        for (int k = 0; k < CPU_NB; k++) begin
            w_pos = (int'(i_ptr) + k) % CPU_NB;
            if (!w_found && i_elig[w_pos]) begin
                w_found      = 1'b1;
                o_gnt[w_pos] = 1'b1;
                o_idx        = PTR_W'(w_pos);
            end
        end
    end

endmodule : cpu_rr_arb
`default_nettype wire

// File: rtl/cpu_poll_sched.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_poll_sched
//  Purpose  : Round-robin scheduler sharing one 64-bit result channel among
//             CPU_NB CPU-server lanes. Grants at most one lane per cycle,
//             forwards its word with the lane index through a one-deep output
//             register, retires each lane after TXN_NB transfers and raises
//             all_done once every lane is retired and the output has drained.
//  Ports    : clk, rst            clock / synchronous active-high reset
//             start               pulse, leaves IDLE
//             req_vld/req_data    per-lane offer (packed [CPU_NB-1:0][63:0])
//             req_rdy             one-hot (or zero) combinational grant
//             out_vld/out_data/out_cpu/out_rdy   result channel
//             busy                FSM in RUN or DRAIN
//             all_done            FSM in DONE, sticky until rst
//             wdog_err            starvation flag (CPU_SCHED_WDOG_EN only)
//  Config   : `define CPU_SCHED_WDOG_EN adds per-lane wait counters and the
//             wdog_err port; otherwise the behaviour is identical.
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_poll_sched
    import cpu_sched_pkg::*;
#(
    parameter int CPU_NB   = 4,
    parameter int TXN_NB   = 16,
    parameter int WDOG_CYC = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [CPU_NB-1:0]              req_vld,
    input  logic [CPU_NB-1:0][DATA_W-1:0]  req_data,
    output logic [CPU_NB-1:0]              req_rdy,
    output logic                           out_vld,
    output logic [DATA_W-1:0]              out_data,
    output logic [$clog2(CPU_NB)-1:0]      out_cpu,
    input  logic                           out_rdy,
    output logic                           busy,
    output logic                           all_done
`ifdef CPU_SCHED_WDOG_EN
    ,
    output logic                           wdog_err
`endif
);

    localparam int PTR_W = $clog2(CPU_NB);
    localparam int CNT_W = $clog2(TXN_NB + 1);

    localparam logic [CNT_W-1:0] c_txn_max = CNT_W'(TXN_NB);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);
    localparam logic [PTR_W-1:0] c_ptr_top = PTR_W'(CPU_NB - 1);

    // Elaboration-time parameter sanity checks.
    if (CPU_NB < 2) begin : g_cfg_cpu_nb
        $error("cpu_poll_sched: CPU_NB must be >= 2");
    end
    if (TXN_NB < 1) begin : g_cfg_txn_nb
        $error("cpu_poll_sched: TXN_NB must be >= 1");
    end
    if (WDOG_CYC < 1) begin : g_cfg_wdog
        $error("cpu_poll_sched: WDOG_CYC must be >= 1");
    end

    state_e                        r_state;
    logic [PTR_W-1:0]              r_ptr;
    logic [CPU_NB-1:0][CNT_W-1:0]  r_cnt;
    logic                          r_out_vld;
    data_t                         r_out_data;
    logic [PTR_W-1:0]              r_out_cpu;
    logic                          r_busy;
    logic                          r_all_done;

    logic [CPU_NB-1:0]             w_elig;
    logic                          w_slot_free;
    logic                          w_all_ret;
    logic [CPU_NB-1:0]             w_gnt;
    logic [PTR_W-1:0]              w_idx;
    logic                          w_xfer;

    // A lane may transfer only while running and not yet retired.
    always_comb begin
        w_elig    = '0;
        w_all_ret = 1'b1;
        for (int i = 0; i < CPU_NB; i++) begin
            w_elig[i] = (r_state == RUN) && req_vld[i] && (r_cnt[i] < c_txn_max);
            if (r_cnt[i] != c_txn_max) begin
                w_all_ret = 1'b0;
            end
        end
    end

    // The output register can take a word if empty or being emptied now,
    // which keeps the channel at one word per cycle.
    assign w_slot_free = !r_out_vld || out_rdy;

    cpu_rr_arb #(
        .CPU_NB (CPU_NB)
    ) u_arb (
        .i_elig (w_elig & {CPU_NB{w_slot_free}}),
        .i_ptr  (r_ptr),
        .o_gnt  (w_gnt),
        .o_idx  (w_idx)
    );

    assign w_xfer = |w_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
            r_out_cpu  <= '0;
            r_busy     <= 1'b0;
            r_all_done <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                    end
                end
                RUN: begin
                    // Retirement is judged on the registered counts, so the
                    // FSM always spends at least one cycle in DRAIN.
                    if (w_all_ret) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!r_out_vld) begin
                        r_state    <= DONE;
                        r_busy     <= 1'b0;
                        r_all_done <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= DONE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            if (w_xfer) begin
                r_out_vld     <= 1'b1;
                r_out_data    <= req_data[w_idx];
                r_out_cpu     <= w_idx;
                r_cnt[w_idx]  <= r_cnt[w_idx] + c_cnt_one;
                r_ptr         <= (w_idx == c_ptr_top) ? '0 : (w_idx + c_ptr_one);
            end else if (r_out_vld && out_rdy) begin
                // Word consumed with nothing behind it; data/cpu hold.
                r_out_vld <= 1'b0;
            end
        end
    end

    assign req_rdy  = w_gnt;
    assign out_vld  = r_out_vld;
    assign out_data = r_out_data;
    assign out_cpu  = r_out_cpu;
    assign busy     = r_busy;
    assign all_done = r_all_done;

`ifdef CPU_SCHED_WDOG_EN
    localparam int WCNT_W = $clog2(WDOG_CYC + 1);
    localparam logic [WCNT_W-1:0] c_wdog_max = WCNT_W'(WDOG_CYC);
    localparam logic [WCNT_W-1:0] c_wdog_one = WCNT_W'(1);

    logic [CPU_NB-1:0][WCNT_W-1:0] r_wait;
    logic                          r_wdog_err;

    // Wait counters saturate at WDOG_CYC; the flag is set on the cycle the
    // counter reaches the limit and stays set until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait     <= '0;
            r_wdog_err <= 1'b0;
        end else begin
            for (int i = 0; i < CPU_NB; i++) begin
                if (w_elig[i] && !w_gnt[i]) begin
                    if (r_wait[i] != c_wdog_max) begin
                        r_wait[i] <= r_wait[i] + c_wdog_one;
                    end
                    if (r_wait[i] == (c_wdog_max - c_wdog_one)) begin
                        r_wdog_err <= 1'b1;
                        $error("cpu_poll_sched: lane %0d starved for %0d cycles", i, WDOG_CYC);
                    end
                end else begin
                    r_wait[i] <= '0;
                end
            end
        end
    end

    assign wdog_err = r_wdog_err;
`endif

endmodule : cpu_poll_sched
`default_nettype wire

// File: tb/tb_cpu_poll_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_poll_sched
//  Purpose  : Self-checking bench for cpu_poll_sched (CPU_NB=4, TXN_NB=16).
//             Directed vector table, hand-written corner sequences and a
//             randomized phase checked against a transaction-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_poll_sched;

    localparam int N   = 4;
    localparam int TXN = 16;

    logic             clk;
    logic             rst;
    logic             start;
    logic [N-1:0]     req_vld;
    logic [N-1:0][63:0] req_data;
    logic [N-1:0]     req_rdy;
    logic             out_vld;
    logic [63:0]      out_data;
    logic [1:0]       out_cpu;
    logic             out_rdy;
    logic             busy;
    logic             all_done;
`ifdef CPU_SCHED_WDOG_EN
    logic             wdog_err;
`endif

    cpu_poll_sched #(
        .CPU_NB   (N),
        .TXN_NB   (TXN),
        .WDOG_CYC (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .req_vld  (req_vld),
        .req_data (req_data),
        .req_rdy  (req_rdy),
        .out_vld  (out_vld),
        .out_data (out_data),
        .out_cpu  (out_cpu),
        .out_rdy  (out_rdy),
        .busy     (busy),
        .all_done (all_done)
`ifdef CPU_SCHED_WDOG_EN
        ,
        .wdog_err (wdog_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Transaction-level model: 0 idle, 1 run, 2 drain, 3 done.
    int          m_state;
    int          m_ptr;
    int          m_cnt [N];
    logic        m_vld;
    logic [63:0] m_data;
    int          m_cpu;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Winner is the eligible lane at the smallest forward distance from ptr.
    function automatic int model_grant();
        int best;
        int bestd;
        int d;
        best  = -1;
        bestd = N;
        if (m_state != 1) return -1;
        if (m_vld && !out_rdy) return -1;
        for (int i = 0; i < N; i++) begin
            if (req_vld[i] && m_cnt[i] < TXN) begin
                d = (i - m_ptr + N) % N;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    task automatic model_update(input int g);
        int  nxt;
        logic all_ret;
        if (rst) begin
            m_state = 0;
            m_ptr   = 0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            m_vld   = 1'b0;
            m_data  = '0;
            m_cpu   = 0;
            return;
        end
        all_ret = 1'b1;
        for (int i = 0; i < N; i++) if (m_cnt[i] != TXN) all_ret = 1'b0;
        nxt = m_state;
        if (m_state == 0 && start)  nxt = 1;
        if (m_state == 1 && all_ret) nxt = 2;
        if (m_state == 2 && !m_vld) nxt = 3;
        if (g >= 0) begin
            m_data = req_data[g];
            m_cpu  = g;
            m_vld  = 1'b1;
            m_cnt[g]++;
            m_ptr  = (g + 1) % N;
        end else if (m_vld && out_rdy) begin
            m_vld = 1'b0;
        end
        m_state = nxt;
    endtask

    // Called at posedge+1 with inputs already driven.
    task automatic tick(input bit chk);
        int g;
        logic [N-1:0] exp_rdy;
        #1;
        g = model_grant();
        exp_rdy = (g >= 0) ? N'(1 << g) : '0;
        if (chk) begin
            check("req_rdy",  64'(req_rdy),  64'(exp_rdy));
            check("out_vld",  64'(out_vld),  64'(m_vld));
            check("out_data", out_data,      m_data);
            check("out_cpu",  64'(out_cpu),  64'(m_cpu));
            check("busy",     64'(busy),     64'(m_state == 1 || m_state == 2));
            check("all_done", 64'(all_done), 64'(m_state == 3));
        end
        @(posedge clk);
        model_update(g);
        #1;
    endtask

    task automatic check_reset_vals();
        #1;
        check("rst_req_rdy",  64'(req_rdy),  64'd0);
        check("rst_out_vld",  64'(out_vld),  64'd0);
        check("rst_out_data", out_data,      64'd0);
        check("rst_out_cpu",  64'(out_cpu),  64'd0);
        check("rst_busy",     64'(busy),     64'd0);
        check("rst_all_done", 64'(all_done), 64'd0);
    endtask

    task automatic set_pattern_data();
        for (int i = 0; i < N; i++) req_data[i] = {32'hDEAD_BEEF, 32'(i)};
    endtask

    task automatic set_random_data();
        for (int i = 0; i < N; i++) req_data[i] = {$urandom, $urandom};
    endtask

    typedef struct {
        logic [N-1:0] vld;
        logic         rdy;
        logic [N-1:0] exp_rdy;
        logic         exp_ov;
        logic [1:0]   exp_cpu;
        logic [63:0]  exp_data;
    } vec_t;

    vec_t tbl [13];

    localparam logic [63:0] D0 = 64'hDEAD_BEEF_0000_0000;
    localparam logic [63:0] D1 = 64'hDEAD_BEEF_0000_0001;
    localparam logic [63:0] D2 = 64'hDEAD_BEEF_0000_0002;
    localparam logic [63:0] D3 = 64'hDEAD_BEEF_0000_0003;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int xfers;
        int cyc;

        // Starts from RUN, ptr 0, empty output register, all counts 0.
        tbl[0]  = '{4'b0100, 1'b1, 4'b0100, 1'b0, 2'd0, 64'd0};
        tbl[1]  = '{4'b0100, 1'b0, 4'b0000, 1'b1, 2'd2, D2};
        tbl[2]  = '{4'b0100, 1'b0, 4'b0000, 1'b1, 2'd2, D2};
        tbl[3]  = '{4'b0100, 1'b0, 4'b0000, 1'b1, 2'd2, D2};
        tbl[4]  = '{4'b0100, 1'b0, 4'b0000, 1'b1, 2'd2, D2};
        tbl[5]  = '{4'b0100, 1'b0, 4'b0000, 1'b1, 2'd2, D2};
        tbl[6]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2, D2};
        tbl[7]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3, D3};
        tbl[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, D0};
        tbl[9]  = '{4'b1010, 1'b1, 4'b0010, 1'b0, 2'd0, D0};
        tbl[10] = '{4'b1010, 1'b0, 4'b0000, 1'b1, 2'd1, D1};
        tbl[11] = '{4'b1010, 1'b1, 4'b1000, 1'b1, 2'd1, D1};
        tbl[12] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3, D3};

        rst     = 1'b1;
        start   = 1'b0;
        req_vld = '0;
        out_rdy = 1'b1;
        set_pattern_data();
        @(posedge clk);
        #1;
        tick(0);
        tick(0);
        rst = 1'b0;
        check_reset_vals();

        // IDLE ignores requests until start.
        req_vld = 4'b1111;
        tick(1);
        tick(1);
        req_vld = '0;
        start = 1'b1;
        tick(1);
        start = 1'b0;

        // Directed table: single lane, stall with frozen outputs, rotation.
        for (int r = 0; r < 13; r++) begin
            req_vld = tbl[r].vld;
            out_rdy = tbl[r].rdy;
            #1;
            check($sformatf("tbl%0d_req_rdy", r),  64'(req_rdy), 64'(tbl[r].exp_rdy));
            check($sformatf("tbl%0d_out_vld", r),  64'(out_vld), 64'(tbl[r].exp_ov));
            check($sformatf("tbl%0d_out_cpu", r),  64'(out_cpu), 64'(tbl[r].exp_cpu));
            check($sformatf("tbl%0d_out_data", r), out_data,     tbl[r].exp_data);
            tick(0);
        end

        // Lane 1 alone until retired; it must then stay ungranted.
        req_vld = 4'b0010;
        out_rdy = 1'b1;
        for (int k = 0; k < 20; k++) tick(1);
        #1;
        check("lane1_retired_rdy", 64'(req_rdy), 64'd0);

        // Random phase until DONE.
        cyc = 0;
        while (m_state != 3 && cyc < 3000) begin
            req_vld = N'($urandom);
            out_rdy = ($urandom_range(0, 3) != 0);
            set_random_data();
            tick(1);
            cyc++;
        end
        #1;
        check("rand_all_done", 64'(all_done), 64'd1);
        check("rand_busy_low", 64'(busy),     64'd0);
        start   = 1'b1;
        req_vld = 4'b1111;
        for (int k = 0; k < 3; k++) tick(1);
        start = 1'b0;
        #1;
        check("done_sticky", 64'(all_done), 64'd1);

        // Full-throughput restart, then reset with a word in flight.
        rst = 1'b1;
        tick(0);
        rst = 1'b0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        req_vld = 4'b1111;
        out_rdy = 1'b1;
        set_pattern_data();
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("rr_seq%0d", k), 64'(req_rdy), 64'(1 << (k % 4)));
            tick(1);
        end
        #1;
        check("pre_rst_out_vld", 64'(out_vld), 64'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_reset_vals();
        tick(1);
        #1;
        check("need_start_rdy", 64'(req_rdy), 64'd0);

        start = 1'b1;
        tick(1);
        start = 1'b0;
        xfers = 0;
        cyc   = 0;
        while (all_done !== 1'b1 && cyc < 200) begin
            set_random_data();
            #1;
            if (req_rdy != '0) xfers++;
            tick(1);
            cyc++;
        end
        check("full_xfer_count", 64'(xfers), 64'(N * TXN));
        check("full_all_done",   64'(all_done), 64'd1);

`ifdef CPU_SCHED_WDOG_EN
        rst = 1'b1;
        tick(0);
        rst = 1'b0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        req_vld = 4'b1000;
        out_rdy = 1'b0;
        for (int k = 0; k < 12; k++) tick(1);
        #1;
        check("wdog_set", 64'(wdog_err), 64'd1);
        out_rdy = 1'b1;
        for (int k = 0; k < 3; k++) tick(1);
        #1;
        check("wdog_sticky", 64'(wdog_err), 64'd1);
        rst = 1'b1;
        tick(0);
        rst = 1'b0;
        #1;
        check("wdog_rst", 64'(wdog_err), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_cpu_poll_sched
`default_nettype wire
